// File: rtl/pattern_sweep_capture.sv
// -----------------------------------------------------------------------------
// pattern_sweep_capture
//
// Purpose
//   Drives every WIDTH-bit pattern, in ascending index order, onto the inputs
//   of a combinational device under test. Each pattern is held for SETTLE
//   cycles, then the single-bit response is sampled. Each sample is published
//   as a record over a valid/ready handshake. It is also accumulated into a
//   2**WIDTH-bit truth table.
//
// Parameters
//   WIDTH   stimulus pattern width in bits (default 5)
//   SETTLE  cycles each pattern is held before sampling, 1..15 (default 1)
//
// Ports
//   CK            in   1         clock, all state updates on the rising edge
//   reset         in   1         synchronous, active-high reset
//   start         in   1         request one exhaustive sweep (seen only in IDLE)
//   N             out  WIDTH     stimulus; bit-reversed index, N[0] = index MSB
//   dut_out       in   1         response of the device under test
//   rec_valid     out  1         record valid (high only in EMIT)
//   rec_ready     in   1         record ready from the consumer
//   rec_pattern   out  WIDTH     pattern index of the current record
//   rec_response  out  1         sampled response of the current record
//   resp_vector   out  2**WIDTH  truth table, bit i = response to pattern i
//   busy          out  1         high in every state except IDLE
//   done          out  1         one-cycle pulse when a sweep completes
//   o_dbg_state   out  2        current FSM state (IDLE=0 APPLY=1 EMIT=2 DONE=3)
//
// Handshake
//   A record transfers on a rising edge where rec_valid and rec_ready are both
//   high. Once rec_valid is raised, it stays high until that transfer happens,
//   and rec_pattern/rec_response do not change while it is held. Only reset
//   can drop rec_valid without a transfer.
// -----------------------------------------------------------------------------
module pattern_sweep_capture #(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 1
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    output logic [WIDTH-1:0]      N,
    input  logic                  dut_out,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [WIDTH-1:0]      rec_pattern,
    output logic                  rec_response,
    output logic [2**WIDTH-1:0]   resp_vector,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            o_dbg_state
);

    localparam int              VEC_W     = 2**WIDTH;
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
    localparam logic [WIDTH-1:0] LAST_PAT = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_pattern;
    logic [3:0]         r_settle;
    logic [WIDTH-1:0]   r_rec_pattern;
    logic               r_rec_response;
    logic [VEC_W-1:0]   r_resp_vector;

    logic               w_settle_last;
    logic               w_handshake;
    logic               w_last_pattern;

    // The settle counter is loaded with SETTLE on entry to APPLY. Its value
    // is 1 on the final APPLY cycle, which is the cycle that samples dut_out.
    assign w_settle_last  = (r_settle == 4'd1);
    assign w_handshake    = (r_state == S_EMIT) && rec_ready;
    assign w_last_pattern = (r_pattern == LAST_PAT);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_APPLY;
                end
            end
            S_APPLY: begin
                if (w_settle_last) begin
                    w_next_state = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_handshake) begin
                    // The counter never wraps. The final record goes to DONE.
                    w_next_state = w_last_pattern ? S_DONE : S_APPLY;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        rec_valid   = (r_state == S_EMIT);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Datapath: pattern/settle counters, record registers, truth table
    // ------------------------------------------------------------------
    always_ff @(posedge CK) begin
        if (reset) begin
            r_pattern      <= '0;
            r_settle       <= 4'd0;
            r_rec_pattern  <= '0;
            r_rec_response <= 1'b0;
            r_resp_vector  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pattern     <= '0;
                        r_settle      <= SETTLE_LD;
                        // The truth table is cleared only when a new sweep
                        // is accepted. After DONE it keeps the last result.
                        r_resp_vector <= '0;
                    end
                end
                S_APPLY: begin
                    r_settle <= r_settle - 4'd1;
                    if (w_settle_last) begin
                        r_rec_pattern            <= r_pattern;
                        r_rec_response           <= dut_out;
                        r_resp_vector[r_pattern] <= dut_out;
                    end
                end
                S_EMIT: begin
                    if (w_handshake && !w_last_pattern) begin
                        r_pattern <= r_pattern + WIDTH'(1);
                        r_settle  <= SETTLE_LD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The stimulus is the pattern index with its bits reversed, so that N[0]
    // carries the index MSB.
    always_comb begin
        N = '0;
        for (int i = 0; i < WIDTH; i++) begin
            N[i] = r_pattern[WIDTH-1-i];
        end
    end

    assign rec_pattern  = r_rec_pattern;
    assign rec_response = r_rec_response;
    assign resp_vector  = r_resp_vector;

endmodule

// File: tb/tb_pattern_sweep_capture.sv
module tb_pattern_sweep_capture;

    logic        CK = 1'b0;
    logic        reset;
    logic        start1;
    logic        start3;
    logic        ready;
    int          mode;
    int          n_vec = 0;
    int          n_err = 0;

    logic [4:0]  N1, N3;
    logic        dut_out1, dut_out3;
    logic        rec_valid1, rec_valid3;
    logic [4:0]  rec_pattern1, rec_pattern3;
    logic        rec_response1, rec_response3;
    logic [31:0] resp_vector1, resp_vector3;
    logic        busy1, busy3;
    logic        done1, done3;
    logic [1:0]  dbg1, dbg3;

    always #5 CK = ~CK;

    // Device models: 0 = XOR of N, 1 = constant 1, 2 = N[4]
    assign dut_out1 = (mode == 0) ? ^N1 : (mode == 1) ? 1'b1 : N1[4];
    assign dut_out3 = N3[4];

    pattern_sweep_capture #(.WIDTH(5), .SETTLE(1)) u_dut (
        .CK(CK), .reset(reset), .start(start1), .N(N1), .dut_out(dut_out1),
        .rec_valid(rec_valid1), .rec_ready(ready), .rec_pattern(rec_pattern1),
        .rec_response(rec_response1), .resp_vector(resp_vector1),
        .busy(busy1), .done(done1), .o_dbg_state(dbg1)
    );

    pattern_sweep_capture #(.WIDTH(5), .SETTLE(3)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3), .N(N3), .dut_out(dut_out3),
        .rec_valid(rec_valid3), .rec_ready(ready), .rec_pattern(rec_pattern3),
        .rec_response(rec_response3), .resp_vector(resp_vector3),
        .busy(busy3), .done(done3), .o_dbg_state(dbg3)
    );

    function automatic logic [4:0] rev5(input logic [4:0] p);
        return {p[0], p[1], p[2], p[3], p[4]};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; ready = 1'b1; mode = 0;
        repeat (3) @(negedge CK);
        n_vec++;
        if ({N1, rec_valid1, rec_pattern1, rec_response1} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_rec got N=%0h v=%0b p=%0h r=%0b want all 0",
                     N1, rec_valid1, rec_pattern1, rec_response1);
        end
        n_vec++;
        if (resp_vector1 !== 32'h0) begin
            n_err++; $display("FAIL reset_vec got %h want 0", resp_vector1);
        end
        n_vec++;
        if ({busy1, done1, dbg1} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl got busy=%0b done=%0b st=%0d want 0 0 0", busy1, done1, dbg1);
        end
        n_vec++;
        if ({busy3, rec_valid3, resp_vector3} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_dut3 got busy=%0b v=%0b vec=%h want 0", busy3, rec_valid3, resp_vector3);
        end
        reset = 1'b0;
        @(negedge CK);
    endtask

    task automatic test_full_sweep();
        int exp_pat = 0;
        int done_cyc = -1;
        int done_cnt = 0;
        mode = 0; ready = 1'b1; start1 = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge CK);
            if (cyc == 1) begin
                start1 = 1'b0;
                n_vec++;
                if ({busy1, N1} !== 6'b1_00000) begin
                    n_err++; $display("FAIL sweep_start got busy=%0b N=%0h want 1 0", busy1, N1);
                end
            end
            if (rec_valid1) begin
                n_vec++;
                if ({rec_pattern1, rec_response1, N1} !== {exp_pat[4:0], ^exp_pat[4:0], rev5(exp_pat[4:0])}) begin
                    n_err++;
                    $display("FAIL sweep_rec got p=%0d r=%0b N=%0h want p=%0d r=%0b N=%0h",
                             rec_pattern1, rec_response1, N1, exp_pat, ^exp_pat[4:0], rev5(exp_pat[4:0]));
                end
                n_vec++;
                if (cyc != 2 * (exp_pat + 1)) begin
                    n_err++; $display("FAIL sweep_timing got cycle %0d want %0d", cyc, 2 * (exp_pat + 1));
                end
                exp_pat++;
            end
            if (done1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        n_vec++;
        if (exp_pat != 32) begin
            n_err++; $display("FAIL sweep_count got %0d records want 32", exp_pat);
        end
        n_vec++;
        if (done_cyc != 65 || done_cnt != 1) begin
            n_err++; $display("FAIL sweep_done got cycle %0d pulses %0d want 65 1", done_cyc, done_cnt);
        end
        n_vec++;
        if (resp_vector1 !== 32'h96696996) begin
            n_err++; $display("FAIL sweep_vec got %h want 96696996", resp_vector1);
        end
        n_vec++;
        if (busy1 !== 1'b0) begin
            n_err++; $display("FAIL sweep_idle got busy=%0b want 0", busy1);
        end
    endtask

    task automatic test_stall();
        int exp_pat = 0;
        int done_cyc = -1;
        int stall_left = 0;
        int stall_seen = 0;
        bit stalled = 1'b0;
        logic [31:0] vec_hold = '0;
        mode = 0; ready = 1'b1; start1 = 1'b1;
        for (int cyc = 1; cyc <= 72; cyc++) begin
            @(negedge CK);
            if (cyc == 1) start1 = 1'b0;
            if (rec_valid1) begin
                if (rec_pattern1 == 5'd5 && !stalled) begin
                    stalled = 1'b1; stall_left = 3; vec_hold = resp_vector1;
                end
                if (stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                    n_vec++;
                    if ({rec_pattern1, N1, resp_vector1} !== {5'd5, rev5(5'd5), vec_hold}) begin
                        n_err++;
                        $display("FAIL stall_hold got p=%0d N=%0h vec=%h want p=5 N=%0h vec=%h",
                                 rec_pattern1, N1, resp_vector1, rev5(5'd5), vec_hold);
                    end
                end else begin
                    ready = 1'b1;
                    n_vec++;
                    if (rec_pattern1 !== exp_pat[4:0]) begin
                        n_err++; $display("FAIL stall_order got p=%0d want %0d", rec_pattern1, exp_pat);
                    end
                    exp_pat++;
                end
            end else if (stall_left == 0 && stalled && stall_seen < 3) begin
                n_vec++; n_err++;
                $display("FAIL stall_valid got rec_valid=0 after %0d stalled cycles want 1", stall_seen);
                stall_seen = 3;
            end
            if (done1 && done_cyc < 0) done_cyc = cyc;
        end
        ready = 1'b1;
        n_vec++;
        if (stall_seen != 3 || exp_pat != 32) begin
            n_err++; $display("FAIL stall_count got stalls=%0d records=%0d want 3 32", stall_seen, exp_pat);
        end
        n_vec++;
        if (done_cyc != 68) begin
            n_err++; $display("FAIL stall_done got cycle %0d want 68", done_cyc);
        end
        n_vec++;
        if (resp_vector1 !== 32'h96696996) begin
            n_err++; $display("FAIL stall_vec got %h want 96696996", resp_vector1);
        end
    endtask

    task automatic test_restart_ignored();
        int exp_pat = 0;
        int done_cyc = -1;
        mode = 0; ready = 1'b1; start1 = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge CK);
            start1 = 1'b0;
            if (rec_valid1) begin
                if (rec_pattern1 == 5'd7) start1 = 1'b1;
                n_vec++;
                if (rec_pattern1 !== exp_pat[4:0]) begin
                    n_err++; $display("FAIL restart_order got p=%0d want %0d", rec_pattern1, exp_pat);
                end
                exp_pat++;
            end
            if (done1 && done_cyc < 0) done_cyc = cyc;
        end
        n_vec++;
        if (done_cyc != 65 || exp_pat != 32) begin
            n_err++; $display("FAIL restart_done got cycle %0d records %0d want 65 32", done_cyc, exp_pat);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        bit seen_done = 1'b0;
        int first_cyc = -1;
        mode = 0; ready = 1'b1; start1 = 1'b1;
        for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
            @(negedge CK);
            start1 = 1'b0;
            if (rec_valid1 && rec_pattern1 == 5'd10) hit = 1'b1;
        end
        n_vec++;
        if (!hit) begin
            n_err++; $display("FAIL midreset_reach got no record 10 want record 10");
        end
        // Reset together with start and a pending handshake.
        reset = 1'b1; start1 = 1'b1;
        @(negedge CK);
        reset = 1'b0; start1 = 1'b0;
        n_vec++;
        if ({busy1, rec_valid1, dbg1, N1, rec_pattern1} !== 14'h0) begin
            n_err++;
            $display("FAIL midreset_state got busy=%0b v=%0b st=%0d N=%0h p=%0d want all 0",
                     busy1, rec_valid1, dbg1, N1, rec_pattern1);
        end
        n_vec++;
        if (resp_vector1 !== 32'h0) begin
            n_err++; $display("FAIL midreset_vec got %h want 0", resp_vector1);
        end
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge CK);
            start1 = 1'b0;
            if (rec_valid1 && first_cyc < 0) begin
                first_cyc = cyc;
                n_vec++;
                if ({rec_pattern1, rec_response1} !== 6'h00 || cyc != 2) begin
                    n_err++;
                    $display("FAIL midreset_resume got p=%0d r=%0b cycle %0d want p=0 r=0 cycle 2",
                             rec_pattern1, rec_response1, cyc);
                end
            end
            if (done1) seen_done = 1'b1;
        end
        n_vec++;
        if (!seen_done || first_cyc < 0) begin
            n_err++; $display("FAIL midreset_finish got done=%0b first=%0d want 1 2", seen_done, first_cyc);
        end
    endtask

    task automatic test_settle3();
        int exp_pat = 0;
        int done_cyc = -1;
        ready = 1'b1; start3 = 1'b1;
        for (int cyc = 1; cyc <= 135; cyc++) begin
            @(negedge CK);
            start3 = 1'b0;
            if (rec_valid3) begin
                n_vec++;
                if ({rec_pattern3, rec_response3} !== {exp_pat[4:0], exp_pat[0]} || cyc != 4 * (exp_pat + 1)) begin
                    n_err++;
                    $display("FAIL settle3_rec got p=%0d r=%0b cycle %0d want p=%0d r=%0b cycle %0d",
                             rec_pattern3, rec_response3, cyc, exp_pat, exp_pat[0], 4 * (exp_pat + 1));
                end
                exp_pat++;
            end
            if (done3 && done_cyc < 0) done_cyc = cyc;
        end
        n_vec++;
        if (done_cyc != 129 || exp_pat != 32) begin
            n_err++; $display("FAIL settle3_done got cycle %0d records %0d want 129 32", done_cyc, exp_pat);
        end
        n_vec++;
        if (resp_vector3 !== 32'hAAAAAAAA) begin
            n_err++; $display("FAIL settle3_vec got %h want aaaaaaaa", resp_vector3);
        end
    endtask

    task automatic test_const_one();
        bit seen_done = 1'b0;
        mode = 1; ready = 1'b1; start1 = 1'b1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge CK);
            start1 = 1'b0;
            if (done1) seen_done = 1'b1;
        end
        n_vec++;
        if (resp_vector1 !== 32'hFFFFFFFF || !seen_done) begin
            n_err++; $display("FAIL const1_vec got %h done=%0b want ffffffff 1", resp_vector1, seen_done);
        end
        start1 = 1'b1;
        @(negedge CK);
        start1 = 1'b0;
        n_vec++;
        if ({busy1, resp_vector1} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL const1_clear got busy=%0b vec=%h want 1 0", busy1, resp_vector1);
        end
        repeat (70) @(negedge CK);
        n_vec++;
        if ({busy1, resp_vector1} !== {1'b0, 32'hFFFFFFFF}) begin
            n_err++; $display("FAIL const1_rerun got busy=%0b vec=%h want 0 ffffffff", busy1, resp_vector1);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_settle3();
        test_const_one();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
